// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM burst scheduler: FSM states, bank and grant constants.
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        GAP  = 3'd4
    } sched_state_t;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/sdram_addr_ptr.sv
// Burst start-address pointer: wrap-around within [b_addr, e_addr), ping-pong bank tracking
// and a pending reload that defers a pointer reset until the current burst has finished.
module sdram_addr_ptr
    import sdram_sched_pkg::*;
#(
    parameter int   ADDR_W   = 24,
    parameter int   LEN_W    = 10,
    parameter bit   IS_READ  = 1'b0,
    parameter logic RST_BANK = BANK0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              reload,
    input  logic              busy,
    input  logic              advance,
    input  logic              pingpang_en,
    input  logic              peer_bank,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              bank
);

    localparam int OFF_W = ADDR_W - 2;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_ptr;
    logic              bank_q, bank_d;
    logic              pend_q, pend_d;
    logic              wrap;

    // In ping-pong mode the top two bits carry the bank, so only the offset is compared.
    always_comb begin
        next_ptr = ptr_q + ADDR_W'(len);
        if (pingpang_en) begin
            wrap = next_ptr[OFF_W-1:0] >= e_addr[OFF_W-1:0];
        end else begin
            wrap = next_ptr >= e_addr;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        bank_d = bank_q;
        pend_d = pend_q;
        if (load) begin
            ptr_d  = b_addr;
            pend_d = 1'b0;
        end else if (advance) begin
            pend_d = 1'b0;
            if (pend_q || reload) begin
                ptr_d = b_addr;
            end else if (wrap) begin
                ptr_d  = b_addr;
                bank_d = IS_READ ? ~peer_bank : ~bank_q;
            end else begin
                ptr_d = next_ptr;
            end
        end else if (reload) begin
            if (busy) begin
                pend_d = 1'b1;
            end else begin
                ptr_d = b_addr;
            end
        end
        if (!pingpang_en) begin
            bank_d = BANK0;
        end
        addr_d = pingpang_en ? {bank_d, 1'b0, ptr_d[OFF_W-1:0]} : ptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            addr_q <= '0;
            bank_q <= RST_BANK;
            pend_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            bank_q <= bank_d;
            pend_q <= pend_d;
        end
    end

    assign addr = addr_q;
    assign bank = bank_q;

endmodule

// File: rtl/sdram_burst_sched.sv
// Write/read burst scheduler between the FIFO pair and the SDRAM command interface.
// Define SDRAM_RR_ARB_EN for round-robin arbitration; otherwise writes always win.
module sdram_burst_sched
    import sdram_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_init_done,
    input  logic [LEN_W-1:0]  i_wr_fifo_num,
    input  logic [LEN_W-1:0]  i_rd_fifo_num,
    input  logic              i_read_valid,
    input  logic              i_pingpang_en,
    input  logic [ADDR_W-1:0] i_wr_b_addr,
    input  logic [ADDR_W-1:0] i_wr_e_addr,
    input  logic [ADDR_W-1:0] i_rd_b_addr,
    input  logic [ADDR_W-1:0] i_rd_e_addr,
    input  logic [LEN_W-1:0]  i_wr_burst_len,
    input  logic [LEN_W-1:0]  i_rd_burst_len,
    input  logic              i_wr_rst,
    input  logic              i_rd_rst,
    output logic              o_wr_req,
    input  logic              i_wr_ack,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_req,
    input  logic              i_rd_ack,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_busy
);

    localparam logic [LEN_W:0] DEPTH_LIM = (LEN_W + 1)'(FIFO_DEPTH);

    sched_state_t   state_q, state_d;
    logic           wr_req_q, wr_req_d;
    logic           rd_req_q, rd_req_d;
    logic           ack_seen_q, ack_seen_d;
    logic           busy_q, busy_d;
    logic           wr_elig, rd_elig;
    logic           grant_wr, grant_rd;
    logic           wr_adv, rd_adv;
    logic           wr_bank, rd_bank;
    logic [LEN_W:0] rd_fill;

    always_comb begin
        rd_fill = {1'b0, i_rd_fifo_num} + {1'b0, i_rd_burst_len};
        wr_elig = (i_wr_fifo_num >= i_wr_burst_len) && (i_wr_burst_len != '0);
        rd_elig = i_read_valid && (i_rd_burst_len != '0) && (rd_fill <= DEPTH_LIM);
    end

`ifdef SDRAM_RR_ARB_EN
    logic last_grant_q, last_grant_d;

    // On a tie the side that was not granted last time wins.
    always_comb begin
        grant_wr     = wr_elig && (!rd_elig || (last_grant_q == GRANT_RD));
        grant_rd     = rd_elig && !grant_wr;
        last_grant_d = last_grant_q;
        if (state_q == IDLE && i_init_done) begin
            if (grant_wr) begin
                last_grant_d = GRANT_WR;
            end else if (grant_rd) begin
                last_grant_d = GRANT_RD;
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            last_grant_q <= GRANT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant_wr = wr_elig;
        grant_rd = rd_elig && !wr_elig;
    end
`endif

    // A burst ends on the falling edge of ack; a drop of init_done is honoured only between bursts.
    always_comb begin
        state_d    = state_q;
        wr_req_d   = wr_req_q;
        rd_req_d   = rd_req_q;
        ack_seen_d = ack_seen_q;
        wr_adv     = 1'b0;
        rd_adv     = 1'b0;
        case (state_q)
            INIT: begin
                if (i_init_done) state_d = IDLE;
            end
            IDLE: begin
                ack_seen_d = 1'b0;
                if (!i_init_done) begin
                    state_d = INIT;
                end else if (grant_wr) begin
                    state_d  = WR;
                    wr_req_d = 1'b1;
                end else if (grant_rd) begin
                    state_d  = RD;
                    rd_req_d = 1'b1;
                end
            end
            WR: begin
                if (i_wr_ack) begin
                    ack_seen_d = 1'b1;
                end else if (ack_seen_q) begin
                    ack_seen_d = 1'b0;
                    wr_req_d   = 1'b0;
                    wr_adv     = 1'b1;
                    state_d    = GAP;
                end
            end
            RD: begin
                if (i_rd_ack) begin
                    ack_seen_d = 1'b1;
                end else if (ack_seen_q) begin
                    ack_seen_d = 1'b0;
                    rd_req_d   = 1'b0;
                    rd_adv     = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                state_d = i_init_done ? IDLE : INIT;
            end
            default: begin
                state_d  = INIT;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d == WR) || (state_d == RD) || (state_d == GAP);
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            state_q    <= INIT;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            ack_seen_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            ack_seen_q <= ack_seen_d;
            busy_q     <= busy_d;
        end
    end

    sdram_addr_ptr #(
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .IS_READ (1'b0),
        .RST_BANK(BANK0)
    ) u_wr_ptr (
        .clk        (i_sysclk),
        .rst        (i_sysrst),
        .load       (state_q == INIT),
        .reload     (i_wr_rst),
        .busy       (state_q == WR),
        .advance    (wr_adv),
        .pingpang_en(i_pingpang_en),
        .peer_bank  (rd_bank),
        .b_addr     (i_wr_b_addr),
        .e_addr     (i_wr_e_addr),
        .len        (i_wr_burst_len),
        .addr       (o_wr_addr),
        .bank       (wr_bank)
    );

    sdram_addr_ptr #(
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .IS_READ (1'b1),
        .RST_BANK(BANK1)
    ) u_rd_ptr (
        .clk        (i_sysclk),
        .rst        (i_sysrst),
        .load       (state_q == INIT),
        .reload     (i_rd_rst),
        .busy       (state_q == RD),
        .advance    (rd_adv),
        .pingpang_en(i_pingpang_en),
        .peer_bank  (wr_bank),
        .b_addr     (i_rd_b_addr),
        .e_addr     (i_rd_e_addr),
        .len        (i_rd_burst_len),
        .addr       (o_rd_addr),
        .bank       (rd_bank)
    );

    assign o_wr_req = wr_req_q;
    assign o_rd_req = rd_req_q;
    assign o_busy   = busy_q;

endmodule
